// File: rtl/dispenser_pkg.sv
// Shared types and constants for the pet food dispenser scheduling logic.
package dispenser_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, DISPENSE, COOLDOWN} disp_state_t;

  localparam int unsigned PORTION_W = 4;
  localparam logic [PORTION_W-1:0] DEFAULT_MAX_PORTION = 4'd9;

  function automatic logic [PORTION_W-1:0] clamp_portion(input logic [PORTION_W-1:0] p,
                                                         input logic [PORTION_W-1:0] max_p);
    return (p > max_p) ? max_p : p;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every DIV cycles after clear.
module tick_prescaler #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] Last = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || (cnt_q == Last)) begin
      cnt_d = '0;
    end
  end

  assign tick = !clear && (cnt_q == Last);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dispense_scheduler.sv
// Arbitrates scheduled/manual portion requests and sequences motor dispensing with cooldown.
module dispense_scheduler
  import dispenser_pkg::*;
#(
  parameter int unsigned          TICK_DIV       = 50000000,
  parameter int unsigned          COOLDOWN_TICKS = 4,
  parameter logic [PORTION_W-1:0] MAX_PORTION    = DEFAULT_MAX_PORTION
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sched_req,
  input  logic [PORTION_W-1:0] sched_portion,
  input  logic                 man_req,
  input  logic [PORTION_W-1:0] man_portion,
  output logic                 motor_on,
  output logic                 busy,
  output logic [PORTION_W-1:0] remaining,
  output logic                 done,
  output logic                 grant_sched,
  output logic                 grant_man
);

  localparam int unsigned CdW = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS) : 1;
  localparam logic [CdW-1:0] CdLast = CdW'(COOLDOWN_TICKS - 1);

  disp_state_t          state_q, state_d;
  logic                 sched_flag_q, sched_flag_d, man_flag_q, man_flag_d;
  logic [PORTION_W-1:0] sched_por_q, sched_por_d, man_por_q, man_por_d;
  logic [PORTION_W-1:0] remaining_q, remaining_d;
  logic [CdW-1:0]       cd_q, cd_d;
  logic                 motor_on_q, motor_on_d, busy_q, busy_d, done_q, done_d;
  logic                 grant_sched_q, grant_sched_d, grant_man_q, grant_man_d;
  logic                 tick;

  // LOAD always restarts the prescaler, so both DISPENSE and COOLDOWN start at a unit boundary.
  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (state_q == LOAD),
    .tick  (tick)
  );

  always_comb begin
    state_d       = state_q;
    sched_flag_d  = sched_flag_q;
    sched_por_d   = sched_por_q;
    man_flag_d    = man_flag_q;
    man_por_d     = man_por_q;
    remaining_d   = remaining_q;
    cd_d          = (state_q == COOLDOWN) ? cd_q : '0;
    motor_on_d    = motor_on_q;
    done_d        = 1'b0;
    grant_sched_d = 1'b0;
    grant_man_d   = 1'b0;

    // A request only lands in an empty slot; otherwise the stored portion wins.
    if (sched_req && !sched_flag_q) begin
      sched_flag_d = 1'b1;
      sched_por_d  = clamp_portion(sched_portion, MAX_PORTION);
    end
    if (man_req && !man_flag_q) begin
      man_flag_d = 1'b1;
      man_por_d  = clamp_portion(man_portion, MAX_PORTION);
    end

    unique case (state_q)
      IDLE: begin
        if (sched_flag_d) begin
          state_d       = LOAD;
          remaining_d   = sched_por_d;
          sched_flag_d  = 1'b0;
          grant_sched_d = 1'b1;
        end else if (man_flag_d) begin
          state_d     = LOAD;
          remaining_d = man_por_d;
          man_flag_d  = 1'b0;
          grant_man_d = 1'b1;
        end
      end
      LOAD: begin
        if (remaining_q != '0) begin
          state_d    = DISPENSE;
          motor_on_d = 1'b1;
        end else begin
          state_d = COOLDOWN;
          done_d  = 1'b1;
        end
      end
      DISPENSE: begin
        if (tick && (remaining_q != '0)) begin
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == 4'd1) begin
            state_d    = COOLDOWN;
            motor_on_d = 1'b0;
            done_d     = 1'b1;
          end
        end
      end
      COOLDOWN: begin
        if (tick) begin
          if (cd_q == CdLast) begin
            state_d = IDLE;
          end else begin
            cd_d = cd_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      sched_flag_q  <= 1'b0;
      sched_por_q   <= '0;
      man_flag_q    <= 1'b0;
      man_por_q     <= '0;
      remaining_q   <= '0;
      cd_q          <= '0;
      motor_on_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      grant_sched_q <= 1'b0;
      grant_man_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      sched_flag_q  <= sched_flag_d;
      sched_por_q   <= sched_por_d;
      man_flag_q    <= man_flag_d;
      man_por_q     <= man_por_d;
      remaining_q   <= remaining_d;
      cd_q          <= cd_d;
      motor_on_q    <= motor_on_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      grant_sched_q <= grant_sched_d;
      grant_man_q   <= grant_man_d;
    end
  end

  assign motor_on    = motor_on_q;
  assign busy        = busy_q;
  assign remaining   = remaining_q;
  assign done        = done_q;
  assign grant_sched = grant_sched_q;
  assign grant_man   = grant_man_q;

endmodule

// File: tb/tb_dispense_scheduler.sv
// Directed and randomized bench for dispense_scheduler with TICK_DIV=4, COOLDOWN_TICKS=2.
module tb_dispense_scheduler;

  localparam int Div = 4;
  localparam int Cd  = 2;
  localparam int MaxP = 9;

  logic       clk = 1'b0;
  logic       reset;
  logic       sched_req, man_req;
  logic [3:0] sched_portion, man_portion;
  logic       motor_on, busy, done, grant_sched, grant_man;
  logic [3:0] remaining;

  int checks = 0;
  int failures = 0;
  int last_wait;

  dispense_scheduler #(
    .TICK_DIV       (Div),
    .COOLDOWN_TICKS (Cd),
    .MAX_PORTION    (4'(MaxP))
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sched_req     (sched_req),
    .sched_portion (sched_portion),
    .man_req       (man_req),
    .man_portion   (man_portion),
    .motor_on      (motor_on),
    .busy          (busy),
    .remaining     (remaining),
    .done          (done),
    .grant_sched   (grant_sched),
    .grant_man     (grant_man)
  );

  always #5 clk = ~clk;

  function automatic int clampp(input int p);
    return (p > MaxP) ? MaxP : p;
  endfunction

  task automatic chk(input string tag, input integer obs, input integer exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; DUT samples the request at the next posedge.
  task automatic pulse_req(input bit s, input bit m, input int sp, input int mp);
    sched_req = s;
    sched_portion = 4'(sp);
    man_req = m;
    man_portion = 4'(mp);
    @(negedge clk);
    sched_req = 1'b0;
    man_req = 1'b0;
  endtask

  // Follows one portion from LOAD until busy drops; optional manual injections at cycle offsets.
  task automatic observe(input bit exp_sched, input int exp_p, input int inj_t1, input int inj_p1,
                         input int inj_t2, input int inj_p2);
    int t, motor, dones, done_t, rem_err, grant_err, exp_rem;
    last_wait = 0;
    while (!busy && last_wait < 60) begin
      @(negedge clk);
      last_wait++;
    end
    chk("load_busy", busy, 1);
    chk(exp_sched ? "load_grant_sched" : "load_grant_man", {grant_sched, grant_man},
        exp_sched ? 2 : 1);
    chk("load_remaining", remaining, exp_p);
    chk("load_motor_off", motor_on, 0);
    t = 0; motor = 0; dones = 0; done_t = -1; rem_err = 0; grant_err = 0;
    while (busy && t < 200) begin
      if (t == inj_t1) begin
        man_req = 1'b1;
        man_portion = 4'(inj_p1);
      end else if (t == inj_t2) begin
        man_req = 1'b1;
        man_portion = 4'(inj_p2);
      end else begin
        man_req = 1'b0;
      end
      @(negedge clk);
      t++;
      if (busy) begin
        motor += int'(motor_on);
        if (done) begin
          dones++;
          done_t = t;
        end
        exp_rem = (t <= Div * exp_p) ? exp_p - (t - 1) / Div : 0;
        if (remaining != 4'(exp_rem)) rem_err++;
        if (grant_sched || grant_man) grant_err++;
      end
    end
    man_req = 1'b0;
    chk("motor_cycles", motor, Div * exp_p);
    chk("done_count", dones, 1);
    chk("done_offset", done_t, Div * exp_p + 1);
    chk("busy_cycles", t, 1 + Div * exp_p + Div * Cd);
    chk("remaining_trace_errors", rem_err, 0);
    chk("extra_grant_errors", grant_err, 0);
    chk("idle_motor_off", motor_on, 0);
  endtask

  // Counts busy/grant cycles over a quiet window; both must stay zero.
  task automatic quiet(input string tag, input int n);
    int activity;
    activity = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy || grant_sched || grant_man || motor_on) activity++;
    end
    chk(tag, activity, 0);
  endtask

  initial begin
    int mode, sp, mp, p, t1;
    bit inj;
    reset = 1'b0;
    sched_req = 1'b0;
    man_req = 1'b0;
    sched_portion = '0;
    man_portion = '0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {motor_on, busy, remaining, done, grant_sched, grant_man}, 0);
    reset = 1'b1;
    @(negedge clk);

    // Single manual request
    pulse_req(0, 1, 0, 3);
    observe(0, 3, -1, 0, -1, 0);
    quiet("quiet_after_single", 3);

    // Simultaneous: scheduled first, manual one idle cycle after cooldown
    pulse_req(1, 1, 2, 5);
    observe(1, 2, -1, 0, -1, 0);
    observe(0, 5, -1, 0, -1, 0);
    chk("simul_idle_gap", last_wait, 1);

    // Clamp
    pulse_req(1, 0, 12, 0);
    observe(1, 9, -1, 0, -1, 0);

    // Zero portion
    pulse_req(0, 1, 0, 0);
    observe(0, 0, -1, 0, -1, 0);

    // Dropped request: 4 captured, 7 dropped
    pulse_req(1, 0, 2, 0);
    observe(1, 2, 2, 4, 5, 7);
    observe(0, 4, -1, 0, -1, 0);
    chk("drop_idle_gap", last_wait, 1);
    quiet("quiet_after_drop", 20);

    // Reset mid-dispense with a request in the reset cycle
    pulse_req(0, 1, 0, 5);
    repeat (6) @(negedge clk);
    chk("pre_reset_motor", motor_on, 1);
    reset = 1'b0;
    man_req = 1'b1;
    man_portion = 4'd3;
    sched_req = 1'b1;
    sched_portion = 4'd2;
    @(negedge clk);
    chk("mid_reset_state", {motor_on, busy, remaining}, 0);
    man_req = 1'b0;
    sched_req = 1'b0;
    reset = 1'b1;
    quiet("quiet_after_reset", 20);
    pulse_req(0, 1, 0, 1);
    observe(0, 1, -1, 0, -1, 0);

    // Randomized rounds against the queue/timing model
    for (int r = 0; r < 10; r++) begin
      mode = $urandom_range(0, 2);
      sp = $urandom_range(0, 15);
      mp = $urandom_range(0, 15);
      pulse_req(mode != 1, mode != 0, sp, mp);
      if (mode == 0) begin
        p = clampp(sp);
        inj = ($urandom_range(0, 1) == 1);
        if (inj) begin
          t1 = $urandom_range(0, Div * p + Div * Cd - 2);
          observe(1, p, t1, mp, t1 + 2, $urandom_range(0, 15));
          observe(0, clampp(mp), -1, 0, -1, 0);
          chk("rand_inj_gap", last_wait, 1);
        end else begin
          observe(1, p, -1, 0, -1, 0);
        end
      end else if (mode == 1) begin
        observe(0, clampp(mp), -1, 0, -1, 0);
      end else begin
        observe(1, clampp(sp), -1, 0, -1, 0);
        observe(0, clampp(mp), -1, 0, -1, 0);
        chk("rand_pair_gap", last_wait, 1);
      end
      quiet("rand_quiet", $urandom_range(1, 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
